// File: rtl/uart_alu_if.sv
// Byte-stream command front end for a combinational ALU: A, B, opcode in; one result byte out.
// Optional inter-byte timeout is compiled in with `define UART_ALU_IF_TIMEOUT_EN.
module uart_alu_if #(
  parameter int OP_W        = 6,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [7:0]      rx_data,
  input  logic [7:0]      alu_result,
  input  logic            tx_done_tick,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [OP_W-1:0] alu_op,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  output logic            busy,
  output logic            err_timeout,
  output logic            err_overrun
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t state;
  logic   in_flight;
  logic   collecting;
  logic   timeout_hit;

  assign in_flight  = (state == EXEC) || (state == SEND) || (state == WAIT_TX);
  assign collecting = (state == WAIT_B) || (state == WAIT_OP);

  // Error pulses are combinational so they line up with the offending cycle.
  assign err_overrun = reset & rx_done_tick & in_flight;

`ifdef UART_ALU_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] idle_cnt;

  // A byte arriving on the expiry cycle wins, so the tick masks the timeout.
  assign timeout_hit = reset & collecting & ~rx_done_tick
                     & (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (collecting && !rx_done_tick && !timeout_hit) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign err_timeout = timeout_hit;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // branch reads the pre-edge values; the reset here is synchronous by design.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= WAIT_A;
      // NOTE: the operand/result registers are plain flops (not a memory), so
      // clearing them on reset is cheap and gives a known ALU input after reset.
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        WAIT_A: begin
          if (rx_done_tick) begin
            alu_a <= rx_data;
            state <= WAIT_B;
            busy  <= 1'b1;
          end
        end
        WAIT_B: begin
          if (rx_done_tick) begin
            alu_b <= rx_data;
            state <= WAIT_OP;
          end else if (timeout_hit) begin
            state <= WAIT_A;
            busy  <= 1'b0;
          end
        end
        WAIT_OP: begin
          if (rx_done_tick) begin
            alu_op <= rx_data[OP_W-1:0];
            state  <= EXEC;
          end else if (timeout_hit) begin
            state <= WAIT_A;
            busy  <= 1'b0;
          end
        end
        EXEC: begin
          // The ALU has had this whole cycle to settle on the new operands.
          tx_data  <= alu_result;
          tx_start <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done_tick) begin
            state <= WAIT_A;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= WAIT_A;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_if.sv
// Self-checking bench for uart_alu_if: randomized byte commands, transaction-level
// reference model feeding scoreboard queues, and a free-running monitor.
`timescale 1ns/1ps
module tb_uart_alu_if;

  localparam int OP_W = 6;
  localparam int TO   = 40;
`ifdef UART_ALU_IF_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk          = 1'b0;
  logic            reset        = 1'b0;
  logic            rx_done_tick = 1'b0;
  logic [7:0]      rx_data      = 8'h00;
  logic            tx_done_tick = 1'b0;
  logic [7:0]      alu_result;
  logic [7:0]      alu_a, alu_b, tx_data;
  logic [OP_W-1:0] alu_op;
  logic            tx_start, busy, err_timeout, err_overrun;

  uart_alu_if #(.OP_W(OP_W), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .alu_result   (alu_result),
    .tx_done_tick (tx_done_tick),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun)
  );

  // Stand-in combinational ALU (environment, not part of the design under test).
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [OP_W-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h01:   return a & b;
      6'h02:   return a | b;
      6'h03:   return a ^ b;
      default: return {a[3:0], b[7:4]} ^ {2'b00, op};
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic flag(input string name, input int at);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, at);
  endtask

  // Scoreboard queues filled by the reference model.
  typedef struct {
    int              at;
    logic [7:0]      data;
    logic [7:0]      a;
    logic [7:0]      b;
    logic [OP_W-1:0] op;
  } resp_t;

  resp_t resp_q[$];
  int    ov_q[$];
  int    to_q[$];

  // Reference model: phase 0/1/2 = expecting A/B/opcode, 3 = response outstanding.
  int              phase    = 0;
  int              last_cyc = 0;
  int              op_cyc   = 0;
  logic [7:0]      m_a      = 8'h00;
  logic [7:0]      m_b      = 8'h00;
  logic [OP_W-1:0] m_op     = '0;
  bit              exp_busy = 1'b0;
  bit              mon_en   = 1'b0;

  task automatic drive_cycle(input bit rx, input logic [7:0] d, input bit txd, input bit rst_n);
    resp_t r;
    @(posedge clk);
    #1;
    rx_done_tick = rx;
    rx_data      = rx ? d : 8'h00;
    tx_done_tick = txd;
    reset        = rst_n;
    exp_busy     = (phase != 0);
    if (!rst_n) begin
      phase = 0;
      while (resp_q.size() > 0 && resp_q[resp_q.size()-1].at > cyc)
        resp_q.delete(resp_q.size() - 1);
      return;
    end
    if (rx) begin
      if (phase == 3) begin
        ov_q.push_back(cyc);
      end else begin
        last_cyc = cyc;
        case (phase)
          0: begin m_a = d; phase = 1; end
          1: begin m_b = d; phase = 2; end
          default: begin
            m_op   = d[OP_W-1:0];
            phase  = 3;
            op_cyc = cyc;
            r.at   = cyc + 2;
            r.data = alu_f(m_a, m_b, m_op);
            r.a    = m_a;
            r.b    = m_b;
            r.op   = m_op;
            resp_q.push_back(r);
          end
        endcase
      end
    end else if (TO_EN && (phase == 1 || phase == 2) && (cyc - last_cyc == TO)) begin
      to_q.push_back(cyc);
      phase = 0;
    end
    if (txd && phase == 3 && cyc >= op_cyc + 3) phase = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap, input bit noise);
    repeat (gap) drive_cycle(1'b0, 8'h00, noise && ($urandom_range(0, 5) == 0), 1'b1);
    drive_cycle(1'b1, d, 1'b0, 1'b1);
  endtask

  task automatic wait_tx_start();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      if (tx_start) return;
    end
    flag("tx_start_wait: no tx_start within 8 cycles", cyc);
  endtask

  // mode: 0 clean, 1 byte inside WAIT_TX, 2 byte together with tx_done, 3 byte in EXEC
  task automatic finish_tx(input int delay, input int mode);
    repeat (delay) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    if (mode == 1) begin
      drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      check("alu_a_after_overrun", alu_a, m_a);
    end
    drive_cycle(mode == 2, 8'($urandom), 1'b1, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int g1, input int g2, input int g3,
                         input int delay, input int mode, input bit noise);
    send_byte(a, g1, noise);
    send_byte(b, g2, noise);
    send_byte(op, g3, noise);
    if (phase == 3) begin
      if (mode == 3) drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
      wait_tx_start();
      finish_tx(delay, mode);
    end
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_alu_a"},       alu_a,       32'h0);
    check({tag, "_alu_b"},       alu_b,       32'h0);
    check({tag, "_alu_op"},      alu_op,      32'h0);
    check({tag, "_tx_data"},     tx_data,     32'h0);
    check({tag, "_tx_start"},    tx_start,    32'h0);
    check({tag, "_busy"},        busy,        32'h0);
    check({tag, "_err_timeout"}, err_timeout, 32'h0);
    check({tag, "_err_overrun"}, err_overrun, 32'h0);
  endtask

  task automatic random_cmds(input int n);
    logic [7:0] a, b, opb;
    int         sel;
    for (int i = 0; i < n; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      opb = 8'($urandom);
      sel = $urandom_range(0, 7);
      case (sel)
        0: opb[5:0] = 6'h20;
        1: opb[5:0] = 6'h22;
        2: opb[5:0] = 6'h01;
        3: opb[5:0] = 6'h02;
        4: opb[5:0] = 6'h03;
        default: ;
      endcase
      run_cmd(a, b, opb, $urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 6),
              $urandom_range(0, 5), $urandom_range(0, 5), 1'b1);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    resp_t      r;
    logic [7:0] held;
    bit         hold;
    hold = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!reset) hold = 1'b0;
        check("busy", busy, exp_busy);
        while (resp_q.size() > 0 && resp_q[0].at < cyc) begin
          flag("tx_start_missing", resp_q[0].at);
          resp_q.delete(0);
        end
        while (ov_q.size() > 0 && ov_q[0] < cyc) begin
          flag("err_overrun_missing", ov_q[0]);
          ov_q.delete(0);
        end
        while (to_q.size() > 0 && to_q[0] < cyc) begin
          flag("err_timeout_missing", to_q[0]);
          to_q.delete(0);
        end
        if (tx_start) begin
          if (resp_q.size() == 0) begin
            flag("tx_start_unexpected", cyc);
          end else begin
            r = resp_q.pop_front();
            check("tx_start_cycle", cyc, r.at);
            check("tx_data", tx_data, r.data);
            check("alu_a", alu_a, r.a);
            check("alu_b", alu_b, r.b);
            check("alu_op", alu_op, r.op);
            held = r.data;
            hold = 1'b1;
          end
        end
        if (tx_done_tick && hold && !tx_start) begin
          check("tx_data_held", tx_data, held);
          hold = 1'b0;
        end
        if (err_overrun) begin
          if (ov_q.size() == 0) flag("err_overrun_unexpected", cyc);
          else check("err_overrun_cycle", cyc, ov_q.pop_front());
        end
        if (err_timeout) begin
          if (to_q.size() == 0) flag("err_timeout_unexpected", cyc);
          else check("err_timeout_cycle", cyc, to_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    mon_en = 1'b1;
    check_all_zero("reset");

    // Example command: 5 + 3 with opcode 0x20.
    run_cmd(8'h05, 8'h03, 8'h20, 0, 0, 0, 3, 0, 1'b0);
    // Opcode upper bits must be masked to OP_W.
    run_cmd(8'h30, 8'hFF, 8'hE2, 1, 1, 1, 2, 0, 1'b0);
    check("alu_op_masked", alu_op, 32'h22);
    // Byte while the response is in WAIT_TX.
    run_cmd(8'h44, 8'h21, 8'h03, 0, 2, 0, 2, 1, 1'b0);

    random_cmds(40);

`ifdef UART_ALU_IF_TIMEOUT_EN
    send_byte(8'h11, 0, 1'b0);
    idle(TO + 5);
    run_cmd(8'h21, 8'h34, 8'h20, 0, 0, 0, 1, 0, 1'b0);
    send_byte(8'h40, 0, 1'b0);
    send_byte(8'h41, 2, 1'b0);
    idle(TO + 2);
    check("alu_a_kept_after_timeout", alu_a, 32'h40);
    check("alu_b_kept_after_timeout", alu_b, 32'h41);
    run_cmd(8'h12, 8'h34, 8'h22, 0, TO - 1, TO - 1, 1, 0, 1'b0);
`else
    run_cmd(8'h12, 8'h34, 8'h20, 0, 2 * TO, 2 * TO, 1, 0, 1'b0);
    check("err_timeout_low", err_timeout, 32'h0);
`endif

    // Reset while waiting for the opcode.
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check_all_zero("reset_wait_op");
    idle(4);

    // Reset while the response is in WAIT_TX.
    send_byte(8'h5A, 0, 1'b0);
    send_byte(8'h0F, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    wait_tx_start();
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check_all_zero("reset_wait_tx");
    idle(10);

    run_cmd(8'h07, 8'h09, 8'h20, 0, 0, 0, 0, 0, 1'b0);
    idle(5);
    @(negedge clk);
    check("resp_q_empty", resp_q.size(), 32'h0);
    check("ov_q_empty", ov_q.size(), 32'h0);
    check("to_q_empty", to_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_alu_if.md
# uart_alu_if

Byte-level command interface between the UART receiver and transmitter and a combinational ALU. It consumes the receiver's `rx_done_tick`/`dout` byte stream and assembles three consecutive bytes (operand A, operand B, opcode) into registered ALU inputs. It then captures the ALU result and hands it to the UART transmitter as a one-byte response. An inter-byte timeout discards partial commands; bytes arriving while a response is in flight are dropped and flagged.

## Interface
- `OP_W`, default 6: opcode width; `alu_op` takes the low `OP_W` bits of the third byte.
- `TIMEOUT_CYC`, default 100000: clk cycles allowed between bytes of one command. Counter width is `$clog2(TIMEOUT_CYC+1)`.
- `clk`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-low; sampled on rising `clk`.
- `rx_done_tick`, in, 1: one-cycle pulse; `rx_data` is valid in the same cycle.
- `rx_data`, in, 8: received byte.
- `alu_result`, in, 8: combinational ALU output derived from `alu_a`, `alu_b`, `alu_op`.
- `tx_done_tick`, in, 1: one-cycle pulse from the transmitter at end of its stop bit.
- `alu_a`, out, 8: registered operand A.
- `alu_b`, out, 8: registered operand B.
- `alu_op`, out, OP_W: registered opcode.
- `tx_start`, out, 1: one-cycle request to the transmitter.
- `tx_data`, out, 8: response byte; stable from the `tx_start` cycle until `tx_done_tick`.
- `busy`, out, 1: high in every state except `WAIT_A`.
- `err_timeout`, out, 1: one-cycle pulse when a partial command is discarded.
- `err_overrun`, out, 1: one-cycle pulse when a byte is dropped.

## Operation
- State machine with states `WAIT_A`, `WAIT_B`, `WAIT_OP`, `EXEC`, `SEND`, `WAIT_TX`.
- `WAIT_A` + `rx_done_tick`: `alu_a <= rx_data`, go to `WAIT_B`, clear the timeout counter.
- `WAIT_B` + `rx_done_tick`: `alu_b <= rx_data`, go to `WAIT_OP`, clear the counter.
- `WAIT_OP` + `rx_done_tick`: `alu_op <= rx_data[OP_W-1:0]`, go to `EXEC`.
- `EXEC`, exactly one cycle: `tx_data <= alu_result`, go to `SEND`.
- `SEND`, exactly one cycle: `tx_start = 1`, go to `WAIT_TX`.
- `WAIT_TX` + `tx_done_tick`: go to `WAIT_A`.
- Timeout, in `WAIT_B`/`WAIT_OP` only:
  - The counter increments every cycle without `rx_done_tick`.
  - Reaching `TIMEOUT_CYC-1` pulses `err_timeout` and returns to `WAIT_A`.
  - `alu_a`/`alu_b`/`alu_op` keep their last values.
- A byte and the timeout in the same cycle: the byte wins and no error is raised.
- `rx_done_tick` in `EXEC`, `SEND` or `WAIT_TX`: the byte is discarded and `err_overrun` pulses the same cycle.
- `rx_done_tick` and `tx_done_tick` in the same cycle in `WAIT_TX`: the byte is dropped (overrun), and the state goes to `WAIT_A`.
- `tx_done_tick` outside `WAIT_TX`: ignored.
- Reset (`reset==0`), including mid-command or mid-send:
  - State goes to `WAIT_A` and the counter is 0.
  - `alu_a`, `alu_b`, `alu_op`, `tx_data` = 0; `tx_start`, `busy`, `err_timeout`, `err_overrun` = 0.

## Timing
- `alu_a`/`alu_b`/`alu_op` update one clk after the capturing `rx_done_tick` cycle.
- Latencies from the opcode `rx_done_tick` (cycle T):
  - `alu_op` valid at T+1 (`EXEC`).
  - `tx_data` registered at the end of T+1.
  - `tx_start` high during T+2 only.
- The ALU has one full cycle (`EXEC`) of combinational settling.
- `busy` rises the cycle after operand A is captured. It falls the cycle after `tx_done_tick`.
- Error pulses are combinational, in the cycle of the offending event, and never wider than one cycle.

## Configuration
- `UART_ALU_IF_TIMEOUT_EN` defined: timeout counter and `err_timeout` are implemented as above.
- Not defined: no counter is synthesised, `err_timeout` is tied to 0, and `WAIT_B`/`WAIT_OP` wait indefinitely.

## Test plan
- Bytes 0x05, 0x03, 0x20 with the ALU modelled as ADD for op 0x20 (result 0x08):
  - `alu_a=0x05`, `alu_b=0x03`, `alu_op=0x20`.
  - One `tx_start` pulse two cycles after the third `rx_done_tick`, with `tx_data=0x08`.
  - `busy` drops after `tx_done_tick`.
- Byte 0xFF followed by a third byte 0xE2: `alu_op=0x22`, confirming the upper bits are masked for `OP_W=6`.
- Partial command: 0x11, then no byte for `TIMEOUT_CYC` cycles → `err_timeout` pulses once, state returns to `WAIT_A`. The next 3 bytes then form a complete new command.
- Byte while in `WAIT_TX` → `err_overrun` pulses once, `alu_a` is unchanged, and no extra `tx_start` occurs.
- Reset asserted in `WAIT_OP` and in `WAIT_TX` → all outputs 0 the next cycle, with no `tx_start`.
- Built without `UART_ALU_IF_TIMEOUT_EN`: a 2× `TIMEOUT_CYC` gap between bytes still completes the command with correct `tx_data`, and `err_timeout` stays 0.
